// File: rtl/mips_dmem_responder_if.sv
// Request/response bus between the MIPS32 core (master) and its data-memory responder (slave).
// Handshake rule for both channels: a transfer happens on a rising edge where valid & ready are both 1;
// the sender holds valid and its payload steady until that edge, and ready never waits on valid.
interface mips_dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mips_dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time, WAIT_CYC wait states, then a held response.
// Define ALIGN_CHECK_EN to fault word-misaligned addresses instead of accessing the containing word.
module mips_dmem_responder #(
    parameter int DEPTH    = 256,
    parameter int WAIT_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    mips_dmem_responder_if.slave  bus,
    output logic                  busy,
    output logic [1:0]            state_dbg
);
    localparam int AW = $clog2(DEPTH);
`ifdef ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        accept, commit, fault, mem_we;

    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;
    logic        lat_mis;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;

    assign idx = lat_addr[AW+1:2];
    // Anything at or above 4*DEPTH bytes is out of range; misalignment only faults when enabled.
    assign fault  = (|lat_addr[31:AW+2]) | (ALIGN_EN & lat_mis);
    assign mem_we = commit & lat_we & ~fault;

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        accept        = 1'b0;
        commit        = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        busy          = 1'b0;
        case (state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    cnt_n   = 4'(WAIT_CYC);
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                busy = 1'b1;
                if (cnt == 4'd0) begin
                    commit  = 1'b1;
                    state_n = S_RESP;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            S_RESP: begin
                busy          = 1'b1;
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_we    <= bus.req_we;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
            lat_be    <= bus.req_be;
            lat_mis   <= |bus.req_addr[1:0];
        end
    end

    // Response payload is only updated at commit, so it stays stable through backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (commit) begin
            err_q   <= fault;
            rdata_q <= (lat_we || fault) ? 32'd0 : mem[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_be[i]) mem[idx][8*i +: 8] <= lat_wdata[8*i +: 8];
            end
        end
    end

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign state_dbg     = state;
endmodule

// File: tb/tb_mips_dmem_responder.sv
// Bench for mips_dmem_responder: a WAIT_CYC=2 instance and a WAIT_CYC=0 instance behind one driver,
// checked against a word-array reference model with an expected-response queue.
module tb_mips_dmem_responder;
    localparam int DEPTH    = 256;
    localparam int WAIT_CYC = 2;
    localparam int TIMEOUT  = 40;

    // clock / reset
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // shared driver signals; sel steers them to instance a (0) or b (1)
    logic        sel;
    logic        req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;

    mips_dmem_responder_if bus_a();
    mips_dmem_responder_if bus_b();
    logic       busy_a, busy_b;
    logic [1:0] dbg_a, dbg_b;

    assign bus_a.req_valid = req_valid & ~sel;
    assign bus_a.req_we    = req_we;
    assign bus_a.req_addr  = req_addr;
    assign bus_a.req_wdata = req_wdata;
    assign bus_a.req_be    = req_be;
    assign bus_a.rsp_ready = rsp_ready & ~sel;
    assign bus_b.req_valid = req_valid & sel;
    assign bus_b.req_we    = req_we;
    assign bus_b.req_addr  = req_addr;
    assign bus_b.req_wdata = req_wdata;
    assign bus_b.req_be    = req_be;
    assign bus_b.rsp_ready = rsp_ready & sel;

    mips_dmem_responder #(.DEPTH(DEPTH), .WAIT_CYC(WAIT_CYC)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave), .busy(busy_a), .state_dbg(dbg_a)
    );
    mips_dmem_responder #(.DEPTH(DEPTH), .WAIT_CYC(0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave), .busy(busy_b), .state_dbg(dbg_b)
    );

    logic        obs_req_ready, obs_rsp_valid, obs_err, obs_busy;
    logic [31:0] obs_rdata;
    assign obs_req_ready = sel ? bus_b.req_ready : bus_a.req_ready;
    assign obs_rsp_valid = sel ? bus_b.rsp_valid : bus_a.rsp_valid;
    assign obs_rdata     = sel ? bus_b.rsp_rdata : bus_a.rsp_rdata;
    assign obs_err       = sel ? bus_b.rsp_err   : bus_a.rsp_err;
    assign obs_busy      = sel ? busy_b          : busy_a;

    // scoreboard: reference memory per instance plus expected {known, err, rdata}
    logic [31:0] ref_mem [2][DEPTH];
    logic        known   [2][DEPTH];
    logic [33:0] exp_q[$];
    int n_checks;
    int n_fail;

    task automatic model_push(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be);
        int   s;
        int   w;
        logic err;
        s   = sel ? 1 : 0;
        w   = int'(addr / 4) % DEPTH;
        err = (addr >= 32'(4 * DEPTH));
`ifdef ALIGN_CHECK_EN
        if (addr % 4 != 0) err = 1'b1;
`endif
        if (we) begin
            if (!err) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[s][w][8*b +: 8] = wdata[8*b +: 8];
                if (be == 4'hF) known[s][w] = 1'b1;
            end
            exp_q.push_back({1'b1, err, 32'd0});
        end else if (err) begin
            exp_q.push_back({1'b1, 1'b1, 32'd0});
        end else begin
            exp_q.push_back({known[s][w], 1'b0, ref_mem[s][w]});
        end
    endtask

    // driver: hold < 0 raises rsp_ready before the response appears; hold > 0 stalls that many cycles
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int hold,
                          output logic [31:0] got_rdata, output logic got_err);
        logic [33:0] exp;
        logic [31:0] first_rdata;
        logic        saw_bad;
        int          lat;
        int          exp_lat;
        model_push(we, addr, wdata, be);
        exp_lat = sel ? 1 : WAIT_CYC + 1;
        @(negedge clk);
        n_checks++;
        if (obs_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL req_ready_idle: got %b want 1", obs_req_ready);
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        rsp_ready = (hold < 0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat     = 0;
        saw_bad = 1'b0;
        while (obs_rsp_valid !== 1'b1 && lat < TIMEOUT) begin
            if (obs_busy !== 1'b1 || obs_req_ready !== 1'b0) saw_bad = 1'b1;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        n_checks++;
        if (lat != exp_lat) begin
            n_fail++;
            $display("FAIL latency: addr %h got %0d cycles want %0d", addr, lat, exp_lat);
        end
        n_checks++;
        if (saw_bad) begin
            n_fail++;
            $display("FAIL busy_in_wait: busy/req_ready wrong while waiting, want busy=1 req_ready=0");
        end
        exp       = exp_q.pop_front();
        got_rdata = obs_rdata;
        got_err   = obs_err;
        n_checks++;
        if (obs_err !== exp[32]) begin
            n_fail++;
            $display("FAIL rsp_err: addr %h we %b got %b want %b", addr, we, obs_err, exp[32]);
        end
        if (exp[33]) begin
            n_checks++;
            if (obs_rdata !== exp[31:0]) begin
                n_fail++;
                $display("FAIL rsp_rdata: addr %h we %b got %h want %h", addr, we, obs_rdata, exp[31:0]);
            end
        end
        first_rdata = obs_rdata;
        // stall with a competing request that must be ignored
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 32'h40;
            req_wdata = $urandom;
            req_be    = 4'hF;
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (obs_rsp_valid !== 1'b1 || obs_rdata !== first_rdata || obs_req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL resp_hold: valid %b rdata %h ready %b want 1 %h 0",
                         obs_rsp_valid, obs_rdata, obs_req_ready, first_rdata);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        n_checks++;
        if (obs_rsp_valid !== 1'b0 || obs_req_ready !== 1'b1 || obs_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_idle: valid %b ready %b busy %b want 0 1 0",
                     obs_rsp_valid, obs_req_ready, obs_busy);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus_a.rsp_valid !== 1'b0 || bus_a.rsp_rdata !== 32'd0 || bus_a.rsp_err !== 1'b0 ||
            busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: valid %b rdata %h err %b busy %b want 0 0 0 0",
                     bus_a.rsp_valid, bus_a.rsp_rdata, bus_a.rsp_err, busy_a);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus_a.req_ready !== 1'b1 || bus_b.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b %b want 1 1", bus_a.req_ready, bus_b.req_ready);
        end
    endtask

    task automatic test_preload;
        logic [31:0] r;
        logic        e;
        for (int w = 0; w < 32; w++) do_req(1'b1, 32'(w * 4), $urandom, 4'hF, 0, r, e);
    endtask

    task automatic test_reset_mid_wait;
        logic [31:0] old, r;
        logic        e;
        old = ref_mem[0][4];
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'hDEAD_BEEF;
        req_be    = 4'hF;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus_a.rsp_valid !== 1'b0 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_wait: valid %b busy %b want 0 0", bus_a.rsp_valid, busy_a);
        end
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus_a.req_ready !== 1'b1 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_after_reset: ready %b busy %b want 1 0", bus_a.req_ready, busy_a);
        end
        do_req(1'b0, 32'h10, 32'd0, 4'h0, 0, r, e);
        n_checks++;
        if (r !== old) begin
            n_fail++;
            $display("FAIL aborted_store: got %h want %h", r, old);
        end
    endtask

    task automatic test_store_load;
        logic [31:0] r;
        logic        e;
        do_req(1'b1, 32'h40, 32'h1234_5678, 4'hF, 0, r, e);
        do_req(1'b0, 32'h40, 32'd0, 4'h3, 0, r, e);
        n_checks++;
        if (r !== 32'h1234_5678 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL store_load: got %h err %b want 12345678 0", r, e);
        end
    endtask

    task automatic test_byte_enable;
        logic [31:0] r;
        logic        e;
        do_req(1'b1, 32'h40, 32'hAABB_CCDD, 4'b0101, 0, r, e);
        do_req(1'b1, 32'h40, 32'hFFFF_FFFF, 4'b0000, 0, r, e);
        do_req(1'b0, 32'h40, 32'd0, 4'h0, 0, r, e);
        n_checks++;
        if (r !== 32'h12BB_56DD) begin
            n_fail++;
            $display("FAIL byte_enable: got %h want 12bb56dd", r);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] r;
        logic        e;
        do_req(1'b0, 32'h40, 32'd0, 4'h0, 5, r, e);
        do_req(1'b0, 32'h40, 32'd0, 4'h0, -1, r, e);
        n_checks++;
        if (r !== 32'h12BB_56DD) begin
            n_fail++;
            $display("FAIL ignored_request: got %h want 12bb56dd", r);
        end
    endtask

    task automatic test_out_of_range;
        logic [31:0] r;
        logic        e;
        do_req(1'b1, 32'h0, 32'h5555_AAAA, 4'hF, 0, r, e);
        do_req(1'b0, 32'h400, 32'd0, 4'h0, 0, r, e);
        n_checks++;
        if (e !== 1'b1 || r !== 32'd0) begin
            n_fail++;
            $display("FAIL oor_load: got %h err %b want 0 1", r, e);
        end
        do_req(1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, 0, r, e);
        do_req(1'b0, 32'h0, 32'd0, 4'h0, 0, r, e);
        n_checks++;
        if (r !== 32'h5555_AAAA) begin
            n_fail++;
            $display("FAIL oor_no_wrap: got %h want 5555aaaa", r);
        end
    endtask

    task automatic test_random;
        logic [31:0] r, addr;
        logic        e;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 4) == 0) addr = $urandom_range(32'h400, 32'hFFFF_FFFF);
            else addr = ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
            do_req(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
                   int'($urandom_range(0, 4)) - 1, r, e);
        end
    endtask

    task automatic test_zero_wait;
        logic [31:0] r;
        logic        e;
        sel = 1'b1;
        do_req(1'b1, 32'h40, 32'hCAFE_F00D, 4'hF, 0, r, e);
        do_req(1'b0, 32'h42, 32'd0, 4'h0, 0, r, e);
        n_checks++;
`ifdef ALIGN_CHECK_EN
        if (e !== 1'b1 || r !== 32'd0) begin
            n_fail++;
            $display("FAIL misaligned: got %h err %b want 0 1", r, e);
        end
`else
        if (e !== 1'b0 || r !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL misaligned: got %h err %b want cafef00d 0", r, e);
        end
`endif
        do_req(1'b0, 32'h1000, 32'd0, 4'h0, 2, r, e);
        sel = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        sel       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_be    = 4'h0;
        rsp_ready = 1'b0;
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < DEPTH; w++) begin
                ref_mem[s][w] = 32'd0;
                known[s][w]   = 1'b0;
            end
        test_reset();
        test_preload();
        test_reset_mid_wait();
        test_store_load();
        test_byte_enable();
        test_backpressure();
        test_out_of_range();
        test_random();
        test_zero_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
